// File: rtl/imr_pkg.sv
// Shared types and constants for the instruction-memory bus responder.
package imr_pkg;

    localparam int INST_W = 67;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRIVE,
        TURN,
        PF_ISSUE,
        PF_WAIT
    } imr_state_t;

endpackage

// File: rtl/imr_lat_cnt.sv
// Loadable down-counter that times the RAM read latency; zero marks the data-valid cycle.
module imr_lat_cnt #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MEM_LAT - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/inst_mem_responder.sv
// Memory-side responder for the shared instruction bus: reads one RAM word and strobes it into the MDR.
// Define INST_MEM_PREFETCH_EN to add a one-entry next-address prefetch buffer.
module inst_mem_responder
    import imr_pkg::*;
#(
    parameter int AW      = 10,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [AW-1:0]     addr,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              MDR_rd,
    output logic              MDR_wr,
    inout  wire  [INST_W-1:0] inst
);

    imr_state_t        state, state_nx;
    logic [AW-1:0]     addr_q;
    logic [INST_W-1:0] data_q;
    logic              oe;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              pf_hit;

`ifdef INST_MEM_PREFETCH_EN
    logic              pf_valid;
    logic [AW-1:0]     pf_tag;
    logic [INST_W-1:0] pf_data;

    assign pf_hit   = pf_valid && (addr == pf_tag);
    assign mem_addr = (state == PF_ISSUE) ? addr_q + AW'(1) : addr_q;
`else
    assign pf_hit   = 1'b0;
    assign mem_addr = addr_q;
`endif

    imr_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_nx = state;
        done     = 1'b0;
        mem_en   = 1'b0;
        oe       = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state)
            IDLE:  if (req) state_nx = pf_hit ? DRIVE : ISSUE;
            ISSUE: begin
                mem_en   = 1'b1;
                cnt_load = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_nx = DRIVE;
            end
            // Yield to the MDR: only drive on a cycle where it has released the bus.
            DRIVE: begin
                oe = !MDR_rd;
                if (!MDR_rd) state_nx = TURN;
            end
            TURN: begin
                done = 1'b1;
`ifdef INST_MEM_PREFETCH_EN
                state_nx = PF_ISSUE;
`else
                state_nx = IDLE;
`endif
            end
`ifdef INST_MEM_PREFETCH_EN
            PF_ISSUE: begin
                mem_en   = 1'b1;
                cnt_load = 1'b1;
                state_nx = PF_WAIT;
            end
            PF_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign MDR_wr = oe;
    assign inst   = oe ? data_q : {INST_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) addr_q <= addr;
            if (state == WAIT && cnt_zero) data_q <= mem_rdata;
`ifdef INST_MEM_PREFETCH_EN
            if (state == IDLE && req && pf_hit) data_q <= pf_data;
`endif
        end
    end

`ifdef INST_MEM_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
        end else if (state == IDLE && req && !pf_hit) begin
            pf_valid <= 1'b0;
        end else if (state == PF_WAIT && cnt_zero) begin
            pf_valid <= 1'b1;
        end
    end

    // NOTE: buffer payload has no reset; pf_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (state == PF_WAIT && cnt_zero) begin
            pf_tag  <= addr_q + AW'(1);
            pf_data <= mem_rdata;
        end
    end
`endif

    // Two drivers on the bus at once would be a system-level fault.
    a_no_contention: assert property (@(posedge clk) disable iff (!rst_n) !(oe && MDR_rd));

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench: directed table, reset-in-DRIVE, latency sweep and randomized fetches.
module tb_inst_mem_responder;

    localparam int AW  = 10;
    localparam int IW  = imr_pkg::INST_W;
    localparam int NI  = 3;
    localparam int LATS [NI] = '{2, 1, 4};
    localparam int LAT = 2;
    localparam logic [IW-1:0] PULL    = {IW{1'b1}};
    localparam logic [IW-1:0] GARBAGE = 67'h3_A5A5_5A5A_0F0F_F0F0;
    localparam logic [IW-1:0] MDR_VAL = 67'h6_C0DE_1234_FEED_0042;
`ifdef INST_MEM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic req_m, sw_req, mdr_rd;
    logic [AW-1:0] addr_m, sw_addr;
    logic          busy [NI];
    logic          done [NI];
    logic          men  [NI];
    logic          mwr  [NI];
    logic [AW-1:0] maddr [NI];
    logic [IW-1:0] mrdata [NI];
    logic [IW-1:0] sw_bus [1:NI-1];
    logic [IW-1:0] ram [1 << AW];
    wire  [IW-1:0] inst_bus;

    int checks   = 0;
    int failures = 0;
    bit            pf_ok;
    logic [AW-1:0] pf_next;

    initial forever #5 clk = ~clk;

    assign inst_bus = mdr_rd ? MDR_VAL : {IW{1'bz}};
    pullup (inst_bus);

    inst_mem_responder #(.AW(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_m), .addr(addr_m),
        .busy(busy[0]), .done(done[0]), .mem_en(men[0]), .mem_addr(maddr[0]),
        .mem_rdata(mrdata[0]), .MDR_rd(mdr_rd), .MDR_wr(mwr[0]), .inst(inst_bus)
    );

    for (genvar g = 1; g < NI; g++) begin : sw_g
        wire [IW-1:0] bus;
        inst_mem_responder #(.AW(AW), .MEM_LAT(LATS[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .req(sw_req), .addr(sw_addr),
            .busy(busy[g]), .done(done[g]), .mem_en(men[g]), .mem_addr(maddr[g]),
            .mem_rdata(mrdata[g]), .MDR_rd(1'b0), .MDR_wr(mwr[g]), .inst(bus)
        );
        assign sw_bus[g] = bus;
    end

    // RAM model: data for a read appears exactly LATS[g] edges after mem_en, garbage otherwise.
    for (genvar g = 0; g < NI; g++) begin : ram_g
        logic          v [LATS[g]];
        logic [AW-1:0] a [LATS[g]];
        always @(posedge clk) begin
            v[0] <= men[g];
            a[0] <= maddr[g];
            for (int i = 1; i < LATS[g]; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
            end
        end
        assign mrdata[g] = (v[LATS[g]-1] === 1'b1) ? ram[a[LATS[g]-1]] : GARBAGE;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic fetch(input logic [AW-1:0] a, input int hold, input bit spur,
                         input logic [IW-1:0] exp_word, input int exp_lat);
        int cyc, done_cyc, wr_cyc, n_men, n_wr, n_done, ds, exp_men;
        bit hit, hold_bad;
        logic [AW-1:0] first_addr;
        logic [IW-1:0] wr_word, bus_done;
        hit = (exp_lat - hold == 2);
        ds = exp_lat - hold - 1;
        exp_men = (hit ? 0 : 1) + (PF ? 1 : 0);
        done_cyc = 0; wr_cyc = 0; n_men = 0; n_wr = 0; n_done = 0; hold_bad = 0;
        first_addr = '0; wr_word = '0; bus_done = '0;
        req_m = 1'b1; addr_m = a; mdr_rd = 1'b0;
        @(posedge clk); #1;
        req_m = 1'b0;
        cyc = 1;
        while (cyc <= 40 && (done_cyc == 0 || busy[0])) begin
            mdr_rd = (hold > 0) && (cyc < ds + hold);
            if (spur && cyc < exp_lat) begin
                req_m = 1'($urandom); addr_m = AW'($urandom);
            end else begin
                req_m = 1'b0;
            end
            #1;
            if (men[0]) begin
                n_men++;
                if (n_men == 1) first_addr = maddr[0];
            end
            if (mwr[0]) begin n_wr++; wr_cyc = cyc; wr_word = inst_bus; end
            if (mdr_rd && (mwr[0] || inst_bus !== MDR_VAL)) hold_bad = 1;
            if (done[0]) begin
                n_done++;
                if (done_cyc == 0) begin done_cyc = cyc; bus_done = inst_bus; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_m = 1'b0; mdr_rd = 1'b0;
        check("fetch_idle_in_budget", busy[0], 1'b0);
        check("done_latency", done_cyc, exp_lat);
        check("done_count", n_done, 1);
        check("mdr_wr_count", n_wr, 1);
        check("mdr_wr_cycle", wr_cyc, exp_lat - 1);
        check("bus_word", wr_word, exp_word);
        check("bus_released_on_done", bus_done, PULL);
        check("mdr_hold_quiet", hold_bad, 1'b0);
        check("mem_en_count", n_men, exp_men);
        if (exp_men > 0)
            check("mem_addr", first_addr, hit ? a + AW'(1) : a);
        pf_ok = PF;
        pf_next = a + AW'(1);
    endtask

    task automatic reset_in_drive(input logic [AW-1:0] a);
        int cyc;
        bit seen;
        req_m = 1'b1; addr_m = a;
        @(posedge clk); #1;
        req_m = 1'b0;
        seen = 0; cyc = 0;
        while (!seen && cyc < 20) begin
            #1;
            if (mwr[0]) seen = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check("rst_drive_seen", seen, 1'b1);
        check("rst_drive_word", inst_bus, ram[a]);
        #1 rst_n = 1'b0;
        #1;
        check("rst_bus_release", inst_bus, PULL);
        check("rst_mdr_wr", mwr[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        pf_ok = 0;
        @(posedge clk); #1;
        check("post_rst_busy", busy[0], 1'b0);
        check("post_rst_done", done[0], 1'b0);
    endtask

    task automatic sweep(input logic [AW-1:0] a);
        int dc [NI];
        int wc [NI];
        int nm [NI];
        logic [IW-1:0] ww [NI];
        for (int g = 0; g < NI; g++) begin dc[g] = 0; wc[g] = 0; nm[g] = 0; ww[g] = '0; end
        sw_req = 1'b1; sw_addr = a;
        @(posedge clk); #1;
        sw_req = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            #1;
            for (int g = 1; g < NI; g++) begin
                if (men[g]) nm[g]++;
                if (mwr[g]) begin wc[g] = cyc; ww[g] = sw_bus[g]; end
                if (done[g] && dc[g] == 0) dc[g] = cyc;
            end
            @(posedge clk); #1;
        end
        for (int g = 1; g < NI; g++) begin
            check($sformatf("sweep_lat%0d_done", LATS[g]), dc[g], LATS[g] + 3);
            check($sformatf("sweep_lat%0d_wr_cycle", LATS[g]), wc[g], LATS[g] + 2);
            check($sformatf("sweep_lat%0d_word", LATS[g]), ww[g], ram[a]);
            check($sformatf("sweep_lat%0d_mem_en", LATS[g]), nm[g], 1 + (PF ? 1 : 0));
            check($sformatf("sweep_lat%0d_idle", LATS[g]), busy[g], 1'b0);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            hold;
        bit            spur;
        logic [IW-1:0] word;
        int            lat;
    } vec_t;

    initial begin
        vec_t vt [4];
        vt[0] = '{10'h005, 0, 1'b0, 67'h1_2345_6789_ABCD_EF01, LAT + 3};
        vt[1] = '{10'h3FF, 3, 1'b0, 67'h7_0F0F_0000_FFFF_1234, LAT + 3 + 3};
        vt[2] = '{10'h000, 0, 1'b1, 67'h2_DEAD_BEEF_0000_0001, PF ? 2 : LAT + 3};
        vt[3] = '{10'h010, 1, 1'b1, 67'h5_5555_AAAA_3333_CCCC, LAT + 3 + 1};

        for (int i = 0; i < (1 << AW); i++)
            ram[i] = {IW'($urandom), 32'($urandom), 32'($urandom)} & ~(IW'(1) << (IW - 1));
        for (int i = 0; i < 4; i++) ram[vt[i].addr] = vt[i].word;

        rst_n = 1'b0; req_m = 1'b0; sw_req = 1'b0; mdr_rd = 1'b0;
        addr_m = '0; sw_addr = '0; pf_ok = 0; pf_next = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy[0], 1'b0);
        check("reset_done", done[0], 1'b0);
        check("reset_mem_en", men[0], 1'b0);
        check("reset_mdr_wr", mwr[0], 1'b0);
        check("reset_mem_addr", maddr[0], '0);
        check("reset_bus", inst_bus, PULL);
        rst_n = 1'b1;
        @(posedge clk); #1;

        reset_in_drive(10'h0AB);

        for (int i = 0; i < 4; i++)
            fetch(vt[i].addr, vt[i].hold, vt[i].spur, vt[i].word, vt[i].lat);

        sweep(10'h123);
        sweep(10'h321);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            int hold;
            bit spur, hit;
            a = (pf_ok && $urandom_range(1, 0) == 1) ? pf_next : AW'($urandom);
            hold = $urandom_range(3, 0);
            spur = 1'($urandom);
            hit = pf_ok && (a == pf_next);
            fetch(a, hold, spur, ram[a], (hit ? 2 : LAT + 3) + hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
